// File: rtl/lut_array_serializer_pkg.sv
// Shared definitions for the LUT-array serializer slice.
//   - default array shape (rows x element width)
//   - element / array word types for the default shape
//   - serializer control states
package lut_array_pkg;

    localparam int DEF_ROWS   = 2;
    localparam int DEF_ELEM_W = 2;

    typedef logic [DEF_ELEM_W-1:0] elem_t;
    typedef elem_t                 word_t [DEF_ROWS];

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage : lut_array_pkg

// File: rtl/lut_array_serializer_if.sv
// Handshake bundle between an array-word producer, the serializer and an
// element consumer.
//   I_valid/I_ready/I            : nested-array word in (I[0] emitted first)
//   O_valid/O_ready/O/O_idx/O_last: one element per beat out
// Modports: slave = serializer side, master = producer/consumer side.
interface lut_array_serializer_if
    import lut_array_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int ELEM_W = DEF_ELEM_W
);
    localparam int IDX_W = $clog2(ROWS);

    logic              I_valid;
    logic              I_ready;
    logic [ELEM_W-1:0] I [ROWS];
    logic              O_valid;
    logic              O_ready;
    logic [ELEM_W-1:0] O;
    logic [IDX_W-1:0]  O_idx;
    logic              O_last;

    modport slave (
        input  I_valid, I, O_ready,
        output I_ready, O_valid, O, O_idx, O_last
    );

    modport master (
        output I_valid, I, O_ready,
        input  I_ready, O_valid, O, O_idx, O_last
    );

endinterface : lut_array_serializer_if

// File: rtl/lut_array_serializer.sv
// Serializes one ROWS x ELEM_W nested-array word into ROWS single-element
// beats, index 0 first. Words may follow back to back with no bubble: the
// next word is taken on the same edge that retires the last beat.
//   CLK         : clock, rising edge
//   ASYNCRESETN : asynchronous active-low reset (drops any word in flight)
//   bus         : lut_array_serializer_if.slave (word in, element out)
module lut_array_serializer
    import lut_array_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int ELEM_W = DEF_ELEM_W
)(
    input  logic                   CLK,
    input  logic                   ASYNCRESETN,
    lut_array_serializer_if.slave  bus
);

    localparam int               IDX_W    = $clog2(ROWS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    state_e            state_r;
    state_e            state_s;
    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W-1:0]  idx_s;
    logic [ELEM_W-1:0] buf_r [ROWS];
    logic              load_s;
    logic              send_s;
    logic              last_s;

    assign send_s = (state_r == ST_SEND);
    assign last_s = (idx_r == LAST_IDX);

    // Control state and element index registers.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
        end
    end

    // Word buffer; loaded only when no element of the previous word is pending.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            for (int k = 0; k < ROWS; k++) begin
                buf_r[k] <= '0;
            end
        end else if (load_s) begin
            for (int k = 0; k < ROWS; k++) begin
                buf_r[k] <= bus.I[k];
            end
        end
    end

    // Next-state logic: capture, advance, or chain into the next word on the last beat.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.I_valid) begin
                    load_s  = 1'b1;
                    idx_s   = '0;
                    state_s = ST_SEND;
                end else begin
                    idx_s   = '0;
                end
            end
            ST_SEND: begin
                if (bus.O_ready) begin
                    if (last_s) begin
                        idx_s = '0;
                        if (bus.I_valid) begin
                            load_s  = 1'b1;
                            state_s = ST_SEND;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    idx_s = idx_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                idx_s   = '0;
            end
        endcase
    end

    // Outputs decode straight from registers; only I_ready looks at O_ready.
    assign bus.O_valid = send_s;
    assign bus.O       = send_s ? buf_r[idx_r] : '0;
    assign bus.O_idx   = idx_r;
    assign bus.O_last  = send_s && last_s;
    assign bus.I_ready = !send_s || (last_s && bus.O_ready);

endmodule : lut_array_serializer

// File: tb/tb_lut_array_serializer.sv
// Self-checking bench for lut_array_serializer: directed vectors on the
// default 2x2 shape plus a randomized 3x4 run against a queue-based model.
module tb_lut_array_serializer;
    import lut_array_pkg::*;

    logic CLK;
    logic ASYNCRESETN;
    int   total;
    int   bad;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    lut_array_serializer_if #(.ROWS(2), .ELEM_W(2)) bus2 ();
    lut_array_serializer_if #(.ROWS(3), .ELEM_W(4)) bus3 ();

    lut_array_serializer #(.ROWS(2), .ELEM_W(2)) dut2 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(bus2.slave));
    lut_array_serializer #(.ROWS(3), .ELEM_W(4)) dut3 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(bus3.slave));

    typedef struct {
        elem_t e0;
        elem_t e1;
        elem_t exp_b0;
        elem_t exp_b1;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic put2(input elem_t e0, input elem_t e1, input logic v);
        bus2.I[0]    = e0;
        bus2.I[1]    = e1;
        bus2.I_valid = v;
    endtask

    // upstream "LUT stage": fixed table of 3x4 words addressed randomly
    logic [3:0] lut3 [16][3];

    initial begin
        vecs[0] = '{e0: 2'b01, e1: 2'b10, exp_b0: 2'b01, exp_b1: 2'b10};
        vecs[1] = '{e0: 2'b00, e1: 2'b11, exp_b0: 2'b00, exp_b1: 2'b11};
        vecs[2] = '{e0: 2'b11, e1: 2'b11, exp_b0: 2'b11, exp_b1: 2'b11};
        vecs[3] = '{e0: 2'b10, e1: 2'b00, exp_b0: 2'b10, exp_b1: 2'b00};
        for (int a = 0; a < 16; a++) begin
            for (int k = 0; k < 3; k++) begin
                lut3[a][k] = 4'(a * 3 + k * 7 + 5);
            end
        end

        total = 0;
        bad   = 0;
        ASYNCRESETN = 1'b0;
        put2(2'b00, 2'b00, 1'b0);
        bus2.O_ready = 1'b0;
        bus3.I_valid = 1'b0;
        bus3.O_ready = 1'b0;
        for (int k = 0; k < 3; k++) bus3.I[k] = 4'h0;

        // reset held 3 cycles, then released
        repeat (3) @(negedge CLK);
        chk("rst_hold_ovalid", 32'(bus2.O_valid), 32'd0);
        chk("rst_hold_iready", 32'(bus2.I_ready), 32'd1);
        ASYNCRESETN = 1'b1;
        @(negedge CLK);
        chk("rst_ovalid", 32'(bus2.O_valid), 32'd0);
        chk("rst_iready", 32'(bus2.I_ready), 32'd1);
        chk("rst_oidx",   32'(bus2.O_idx),   32'd0);
        chk("rst_o",      32'(bus2.O),       32'd0);
        chk("rst_olast",  32'(bus2.O_last),  32'd0);
        chk("rst3_iready", 32'(bus3.I_ready), 32'd1);

        // table-driven single words, sink always ready
        bus2.O_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            put2(vecs[v].e0, vecs[v].e1, 1'b1);
            #1;
            chk("sw_idle_iready", 32'(bus2.I_ready), 32'd1);
            @(negedge CLK);
            put2(vecs[v].e0, vecs[v].e1, 1'b0);
            #1;
            chk("sw_b0_valid", 32'(bus2.O_valid), 32'd1);
            chk("sw_b0_o",     32'(bus2.O),       32'(vecs[v].exp_b0));
            chk("sw_b0_idx",   32'(bus2.O_idx),   32'd0);
            chk("sw_b0_last",  32'(bus2.O_last),  32'd0);
            chk("sw_b0_iready", 32'(bus2.I_ready), 32'd0);
            @(negedge CLK); #1;
            chk("sw_b1_o",     32'(bus2.O),       32'(vecs[v].exp_b1));
            chk("sw_b1_idx",   32'(bus2.O_idx),   32'd1);
            chk("sw_b1_last",  32'(bus2.O_last),  32'd1);
            chk("sw_b1_iready", 32'(bus2.I_ready), 32'd1);
            @(negedge CLK); #1;
            chk("sw_done_valid", 32'(bus2.O_valid), 32'd0);
        end

        // backpressure on beat 0 for 4 cycles
        bus2.O_ready = 1'b0;
        put2(2'b01, 2'b10, 1'b1);
        @(negedge CLK);
        put2(2'b01, 2'b10, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("bp_hold_o",      32'(bus2.O),       32'h1);
            chk("bp_hold_idx",    32'(bus2.O_idx),   32'd0);
            chk("bp_hold_valid",  32'(bus2.O_valid), 32'd1);
            chk("bp_hold_iready", 32'(bus2.I_ready), 32'd0);
            @(negedge CLK);
        end
        bus2.O_ready = 1'b1;
        #1;
        chk("bp_rel_o", 32'(bus2.O), 32'h1);
        @(negedge CLK); #1;
        chk("bp_b1_o",    32'(bus2.O),      32'h2);
        chk("bp_b1_last", 32'(bus2.O_last), 32'd1);
        @(negedge CLK); #1;
        chk("bp_done_valid", 32'(bus2.O_valid), 32'd0);

        // back-to-back words A={10,01} then B={11,00}
        put2(2'b01, 2'b10, 1'b1);
        @(negedge CLK);
        put2(2'b00, 2'b11, 1'b1);
        #1;
        chk("b2b_a0_o", 32'(bus2.O), 32'h1);
        chk("b2b_a0_iready", 32'(bus2.I_ready), 32'd0);
        @(negedge CLK); #1;
        chk("b2b_a1_o", 32'(bus2.O), 32'h2);
        chk("b2b_a1_iready", 32'(bus2.I_ready), 32'd1);
        @(negedge CLK);
        put2(2'b00, 2'b11, 1'b0);
        #1;
        chk("b2b_b0_valid", 32'(bus2.O_valid), 32'd1);
        chk("b2b_b0_o",   32'(bus2.O),     32'h0);
        chk("b2b_b0_idx", 32'(bus2.O_idx), 32'd0);
        chk("b2b_b0_iready", 32'(bus2.I_ready), 32'd0);
        @(negedge CLK); #1;
        chk("b2b_b1_o", 32'(bus2.O), 32'h3);
        chk("b2b_b1_last", 32'(bus2.O_last), 32'd1);
        chk("b2b_b1_iready", 32'(bus2.I_ready), 32'd1);
        @(negedge CLK); #1;
        chk("b2b_done_valid", 32'(bus2.O_valid), 32'd0);

        // asynchronous reset right after beat 0 of A
        bus2.O_ready = 1'b0;
        put2(2'b01, 2'b10, 1'b1);
        @(negedge CLK);
        put2(2'b01, 2'b10, 1'b0);
        #1;
        chk("mr_a0_o", 32'(bus2.O), 32'h1);
        #1;
        ASYNCRESETN = 1'b0;
        #1;
        chk("mr_drop_valid",  32'(bus2.O_valid), 32'd0);
        chk("mr_drop_iready", 32'(bus2.I_ready), 32'd1);
        chk("mr_drop_o",      32'(bus2.O),       32'd0);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;
        bus2.O_ready = 1'b1;
        put2(2'b00, 2'b11, 1'b1);
        @(negedge CLK);
        put2(2'b00, 2'b11, 1'b0);
        #1;
        chk("mr_b0_o",   32'(bus2.O),     32'h0);
        chk("mr_b0_idx", 32'(bus2.O_idx), 32'd0);
        chk("mr_b0_valid", 32'(bus2.O_valid), 32'd1);
        @(negedge CLK); #1;
        chk("mr_b1_o",   32'(bus2.O),     32'h3);
        chk("mr_b1_idx", 32'(bus2.O_idx), 32'd1);
        @(negedge CLK); #1;
        chk("mr_done_valid", 32'(bus2.O_valid), 32'd0);
        bus2.O_ready = 1'b0;

        // randomized 3x4 run against a queue of pending (element, index) beats
        begin
            logic [3:0]  pend_e [$];
            int          pend_i [$];
            logic [3:0]  cur [3];
            bit          have;
            int          sent;
            int          cyc;
            bit          in_fire;
            bit          out_fire;
            bit          exp_ready;
            have = 1'b0;
            sent = 0;
            cyc  = 0;
            while ((sent < 1000 || have || pend_e.size() != 0) && cyc < 40000) begin
                @(negedge CLK);
                cyc++;
                if (!have && sent < 1000 && ($urandom_range(0, 3) != 0)) begin
                    int a;
                    a = $urandom_range(0, 15);
                    for (int k = 0; k < 3; k++) cur[k] = lut3[a][k] ^ 4'($urandom_range(0, 15));
                    have = 1'b1;
                end
                bus3.I_valid = have;
                for (int k = 0; k < 3; k++) bus3.I[k] = have ? cur[k] : 4'($urandom_range(0, 15));
                bus3.O_ready = ($urandom_range(0, 9) < 7);
                #1;
                exp_ready = (pend_e.size() == 0) || (pend_e.size() == 1 && bus3.O_ready);
                chk("rnd_ovalid", 32'(bus3.O_valid), 32'(pend_e.size() != 0));
                chk("rnd_iready", 32'(bus3.I_ready), 32'(exp_ready));
                if (pend_e.size() != 0) begin
                    chk("rnd_o",    32'(bus3.O),      32'(pend_e[0]));
                    chk("rnd_idx",  32'(bus3.O_idx),  32'(pend_i[0]));
                    chk("rnd_last", 32'(bus3.O_last), 32'(pend_i[0] == 2));
                end
                out_fire = (pend_e.size() != 0) && bus3.O_ready;
                in_fire  = have && exp_ready;
                if (out_fire) begin
                    void'(pend_e.pop_front());
                    void'(pend_i.pop_front());
                end
                if (in_fire) begin
                    for (int k = 0; k < 3; k++) begin
                        pend_e.push_back(cur[k]);
                        pend_i.push_back(k);
                    end
                    have = 1'b0;
                    sent++;
                end
            end
            bus3.I_valid = 1'b0;
            chk("rnd_words_sent", 32'(sent), 32'd1000);
            chk("rnd_drained", 32'(pend_e.size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_lut_array_serializer
